// File: rtl/obi_arb_pkg.sv
// ============================================================================
// Module   : obi_arb_pkg
// Purpose  : Shared types and widths for the OBI instr/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_arb_pkg;

    localparam int OBI_AW = 32;
    localparam int OBI_DW = 32;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_I    = 2'd1,
        LOCK_D    = 2'd2
    } lock_state_e;

endpackage

`default_nettype wire

// File: rtl/obi_id_fifo.sv
// ============================================================================
// Module   : obi_id_fifo
// Purpose  : Small FIFO of 1-bit requester IDs for in-order response routing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_id_fifo #(
    parameter  int DEPTH   = 2,
    localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_push_id,
    input  logic               i_pop,
    output logic               o_head,
    output logic               o_full,
    output logic               o_empty,
    output logic [c_CNT_W-1:0] o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]   r_mem;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(DEPTH - 1)) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot the push needs
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_push_id;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/obi_mem_arbiter.sv
// ============================================================================
// Module   : obi_mem_arbiter
// Purpose  : Shares one OBI memory port between instruction fetch and data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_PRIO       = 0
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              instr_req_i,
    input  logic [OBI_AW-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [OBI_DW-1:0] instr_rdata_o,
    input  logic              data_req_i,
    input  logic [OBI_AW-1:0] data_addr_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [OBI_DW-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [OBI_DW-1:0] data_rdata_o,
    output logic              mem_req_o,
    output logic [OBI_AW-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [OBI_DW-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [OBI_DW-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    lock_state_e        r_lock;
    lock_state_e        w_lock_next;
    req_id_e            r_last;
    logic               r_err;
    logic               r_out_en;
    req_id_e            w_sel;
    logic               w_any;
    logic               w_lock_hold;
    logic               w_lock_drop;
    logic               w_active;
    logic               w_full;
    logic               w_empty;
    logic               w_head;
    logic               w_gnt;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count;

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst_i),
        .i_push    (w_gnt),
        .i_push_id (w_sel == REQ_DATA),
        .i_pop     (mem_rvalid_i),
        .o_head    (w_head),
        .o_full    (),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // Outputs stay quiet during reset and for the cycle that follows it
    assign w_active = ~rst_i & r_out_en;
    assign w_full   = (w_count == c_CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        w_sel       = REQ_INSTR;
        w_any       = 1'b0;
        w_lock_hold = 1'b0;
        case (r_lock)
            LOCK_I: if (instr_req_i) begin
                w_sel       = REQ_INSTR;
                w_any       = 1'b1;
                w_lock_hold = 1'b1;
            end
            LOCK_D: if (data_req_i) begin
                w_sel       = REQ_DATA;
                w_any       = 1'b1;
                w_lock_hold = 1'b1;
            end
            default: ;
        endcase
        if (!w_lock_hold && !w_full) begin
            w_any = instr_req_i | data_req_i;
            if (instr_req_i && data_req_i) begin
                if (DATA_PRIO != 0) w_sel = REQ_DATA;
                else                w_sel = (r_last == REQ_DATA) ? REQ_INSTR : REQ_DATA;
            end else if (data_req_i) begin
                w_sel = REQ_DATA;
            end
        end
    end

    assign w_lock_drop = (r_lock != LOCK_NONE) & ~w_lock_hold;
    assign mem_req_o   = w_active & w_any;
    assign w_gnt       = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = w_gnt & (w_sel == REQ_INSTR);
    assign data_gnt_o  = w_gnt & (w_sel == REQ_DATA);

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (w_sel == REQ_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o = instr_addr_i;
                mem_be_o   = 4'hF;
            end
        end
    end

    assign w_pop          = mem_rvalid_i & ~w_empty;
    assign instr_rvalid_o = w_active & w_pop & ~w_head;
    assign data_rvalid_o  = w_active & w_pop & w_head;
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign err_o          = r_err;

    always_comb begin
        w_lock_next = LOCK_NONE;
        if (mem_req_o && !mem_gnt_i) begin
            w_lock_next = (w_sel == REQ_DATA) ? LOCK_D : LOCK_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_lock   <= LOCK_NONE;
            r_last   <= REQ_DATA;
            r_err    <= 1'b0;
            r_out_en <= 1'b0;
        end else begin
            r_lock   <= w_lock_next;
            r_out_en <= 1'b1;
            if (w_gnt) begin
                r_last <= w_sel;
            end
            if ((mem_rvalid_i && w_empty) || w_lock_drop) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_obi_mem_arbiter.sv
// ============================================================================
// Module   : tb_obi_mem_arbiter
// Purpose  : Self-checking bench for obi_mem_arbiter against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_mem_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        err_o;

    always #5 clk = ~clk;

    obi_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .DATA_PRIO(0)) dut (
        .clk(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: queue of outstanding requester IDs (0 instr, 1 data), lock owner
    // (0 none, 1 instr, 2 data), last granted ID, sticky error, output enable.
    int m_q[$];
    int m_lock, m_last;
    bit m_err, m_en;
    bit e_act, e_req, e_gnt, e_drop;
    int e_sel, e_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_eval();
        bit hold = 0;
        e_sel  = 0;
        e_req  = 0;
        e_act  = !rst_i && m_en;
        if (m_lock == 1 && instr_req_i) begin hold = 1; e_sel = 0; e_req = 1; end
        if (m_lock == 2 && data_req_i)  begin hold = 1; e_sel = 1; e_req = 1; end
        if (!hold && m_q.size() < MAXO) begin
            e_req = instr_req_i || data_req_i;
            if (instr_req_i && data_req_i) e_sel = 1 - m_last;
            else                           e_sel = data_req_i ? 1 : 0;
        end
        e_drop = (m_lock != 0) && !hold;
        e_req  = e_req && e_act;
        e_gnt  = e_req && mem_gnt_i;
        e_pop  = (mem_rvalid_i && m_q.size() > 0) ? m_q[0] : -1;
    endtask

    task automatic compare();
        bit irv, drv;
        irv = e_act && e_pop == 0;
        drv = e_act && e_pop == 1;
        chk("mem_req", mem_req_o, e_req);
        chk("instr_gnt", instr_gnt_o, e_gnt && e_sel == 0);
        chk("data_gnt", data_gnt_o, e_gnt && e_sel == 1);
        chk("instr_rvalid", instr_rvalid_o, irv);
        chk("data_rvalid", data_rvalid_o, drv);
        chk("instr_rdata", instr_rdata_o, irv ? mem_rdata_i : 32'h0);
        chk("data_rdata", data_rdata_o, drv ? mem_rdata_i : 32'h0);
        chk("err", err_o, m_err);
        if (e_req) begin
            chk("mem_addr", mem_addr_o, e_sel == 1 ? data_addr_i : instr_addr_i);
            chk("mem_we", mem_we_o, e_sel == 1 ? data_we_i : 1'b0);
            chk("mem_be", mem_be_o, e_sel == 1 ? data_be_i : 4'hF);
            if (e_sel == 1) chk("mem_wdata", mem_wdata_o, data_wdata_i);
        end else if (!e_act) begin
            chk("quiet_payload", {mem_addr_o[27:0], mem_we_o, mem_be_o[2:0]} | mem_wdata_o, 32'h0);
        end
    endtask

    task automatic model_update();
        if (rst_i) begin
            m_q.delete();
            m_lock = 0; m_last = 1; m_err = 0; m_en = 0;
        end else begin
            m_en = 1;
            if (mem_rvalid_i) begin
                if (m_q.size() == 0) m_err = 1;
                else void'(m_q.pop_front());
            end
            if (e_drop) m_err = 1;
            if (e_gnt) begin m_q.push_back(e_sel); m_last = e_sel; end
            m_lock = (e_req && !mem_gnt_i) ? (e_sel == 0 ? 1 : 2) : 0;
        end
    endtask

    task automatic settle(); #4; model_eval(); compare(); endtask
    task automatic tick();   model_update(); @(posedge clk); #1; endtask

    task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                         input bit dwe, input logic [31:0] dwd, input bit g, input bit rv,
                         input logic [31:0] rd);
        instr_req_i = ir; instr_addr_i = ia; data_req_i = dr; data_addr_i = da;
        data_we_i = dwe; data_wdata_i = dwd; data_be_i = 4'hF;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; settle(); tick(); rst_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_q.size() > 0; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A0000 + i);
            settle(); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    bit          i_hold, d_hold;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        @(posedge clk); #1;
        m_q.delete(); m_lock = 0; m_last = 1; m_err = 0; m_en = 0;
        do_reset();

        // Fetch only, through the quiet post-reset cycle
        drive(1, 32'h80, 0, 0, 0, 0, 1, 0, 0);
        settle(); chk("t1_quiet", mem_req_o, 0); tick();
        settle();
        chk("t1_addr", mem_addr_o, 32'h80); chk("t1_be", mem_be_o, 4'hF);
        chk("t1_we", mem_we_o, 0); chk("t1_gnt", instr_gnt_o, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h13);
        settle();
        chk("t1_rvalid", instr_rvalid_o, 1); chk("t1_rdata", instr_rdata_o, 32'h13);
        chk("t1_drvalid", data_rvalid_o, 0);
        tick();

        // Round-robin tie starting with instr after reset
        do_reset();
        drive(1, 32'h100, 1, 32'h400, 0, 32'h0, 1, 0, 0);
        settle(); tick();
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = (k > 0); mem_rdata_i = 32'h1000 + k;
            settle();
            chk("t2_igrant", instr_gnt_o, (k % 2) == 0);
            chk("t2_dgrant", data_gnt_o, (k % 2) == 1);
            if (k > 0) chk("t2_route", data_rvalid_o, (k % 2) == 0);
            tick();
        end
        drain();

        // Stall lock holds the data payload
        for (int c = 0; c < 4; c++) begin
            drive(c >= 1, 32'h200, 1, 32'h1000, 1, 32'hDEADBEEF, c == 3, 0, 0);
            settle();
            chk("t3_addr", mem_addr_o, 32'h1000);
            chk("t3_igrant", instr_gnt_o, 0);
            chk("t3_dgrant", data_gnt_o, c == 3);
            tick();
        end
        drain();

        // Full, then simultaneous push/pop
        do_reset();
        drive(1, 32'h200, 0, 0, 0, 0, 1, 0, 0); settle(); tick();
        settle(); tick();
        drive(1, 32'h204, 0, 0, 0, 0, 1, 0, 0); settle(); tick();
        drive(1, 32'h208, 1, 32'h300, 0, 0, 1, 0, 0);
        settle(); chk("t4_full", mem_req_o, 0); tick();
        mem_rvalid_i = 1; mem_rdata_i = 32'hA;
        settle(); chk("t4_full_pop", mem_req_o, 0); chk("t4_rv", instr_rvalid_o, 1); tick();
        mem_rvalid_i = 0;
        settle(); chk("t4_req_again", mem_req_o, 1); chk("t4_dgnt", data_gnt_o, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hB);
        settle(); chk("t5_pre", instr_rvalid_o, 1); tick();
        drive(1, 32'h20C, 0, 0, 0, 0, 1, 1, 32'hC);
        settle(); chk("t5_gnt", instr_gnt_o, 1); chk("t5_older", data_rvalid_o, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hD);
        settle(); chk("t5_count1", instr_rvalid_o, 1); chk("t5_rdata", instr_rdata_o, 32'hD); tick();

        // Spurious response sets a sticky error; reset clears it
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hE);
        settle(); chk("t6_err0", err_o, 0); tick();
        mem_rvalid_i = 0;
        settle(); chk("t6_err1", err_o, 1); tick();
        settle(); chk("t6_sticky", err_o, 1); tick();
        do_reset();
        drive(1, 32'h40, 1, 32'h44, 0, 0, 1, 0, 0);
        settle(); chk("t6_err_clr", err_o, 0); tick();
        settle(); chk("t6_last_data", instr_gnt_o, 1); tick();
        drain();

        // Randomized traffic that respects OBI request stability
        i_hold = 0; d_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            rst_i = ($urandom_range(399) == 0);
            if (rst_i) begin i_hold = 0; d_hold = 0; end
            if (!i_hold) begin
                instr_req_i  = $urandom_range(1);
                instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_hold) begin
                data_req_i   = $urandom_range(1);
                data_addr_i  = $urandom;
                data_we_i    = $urandom_range(1);
                data_be_i    = 4'($urandom);
                data_wdata_i = $urandom;
            end
            mem_gnt_i    = ($urandom_range(3) != 0);
            mem_rvalid_i = (m_q.size() > 0) && ($urandom_range(2) != 0);
            mem_rdata_i  = $urandom;
            settle();
            i_hold = !rst_i && instr_req_i && !(e_gnt && e_sel == 0);
            d_hold = !rst_i && data_req_i && !(e_gnt && e_sel == 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one OBI-style memory port between the core's instruction-fetch and data interfaces, for single-port memory integration of the core.
- Arbitrates requests and holds each selection stable until it is granted.
- Tracks outstanding transactions in an ID FIFO and routes each memory response back to the requester that issued it.
- Sits between the core's instr_*/data_* ports and the shared memory model or bus.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions; must be a power of 2 and >= 1.
- DATA_PRIO, 0: 0 = round-robin arbitration; 1 = data always wins a tie.

Ports:
- clk  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch response data
- data_req_i  in  1  data request
- data_addr_i  in  32  data address
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data response data
- mem_req_o  out  1  memory request
- mem_addr_o  out  32  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory response data
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_i is synchronous and active-high.
  - On reset: lock cleared, ID FIFO emptied, count = 0, last_grant = DATA (so instr wins the first round-robin tie), err_o = 0.
- Output values:
  - mem_req_o, *_gnt_o and *_rvalid_o are combinational off registered state.
  - While rst_i is high and in the cycle after it, all of these are 0 and all mem_* payloads are 0.
- Arbitration (state LOCK_NONE):
  - full = (count == MAX_OUTSTANDING).
  - If full, mem_req_o = 0 and both grants = 0.
  - Otherwise, if exactly one requester is active, it is selected.
  - If both are active, the winner is DATA when DATA_PRIO=1; otherwise it is the requester that is not last_grant.
  - mem_req_o = 1, and the mem_* payload is muxed from the winner. For instr, we = 0 and be = 4'hF.
- Lock:
  - If mem_req_o=1 and mem_gnt_i=0, the next state is LOCK_I or LOCK_D.
  - While locked, the locked requester stays selected regardless of the other's request, preserving OBI address stability.
  - Unlock only on mem_gnt_i.
  - A locked requester that drops its req (protocol violation) sets err_o and unlocks.
- Grant:
  - winner_gnt_o = mem_gnt_i & mem_req_o, with zero added latency; the loser's gnt is 0.
  - On grant: push the winner's ID (0 = instr, 1 = data) into the FIFO and update last_grant.
- Response:
  - Memory responses are in-order.
  - On mem_rvalid_i, pop the FIFO head; assert that requester's rvalid with rdata = mem_rdata_i. The other rvalid stays 0 and its rdata is 0.
  - rvalid may arrive no earlier than the cycle after its grant.
- Count rules:
  - Push and pop in the same cycle leave count unchanged. This is legal when full: the pop frees a slot, but full is evaluated on registered count, so no grant is issued that cycle.
  - mem_rvalid_i with count == 0 sets err_o and is otherwise ignored.
  - FIFO pointers wrap modulo MAX_OUTSTANDING.
- Mid-operation reset: outstanding transactions are dropped and responses arriving after reset are flagged via err_o. The memory must be reset alongside.
- err_o clears only on reset.

Decomposition:
- Package obi_arb_pkg:
  - typedef enum {REQ_INSTR=0, REQ_DATA=1} req_id_e
  - typedef enum {LOCK_NONE, LOCK_I, LOCK_D} lock_state_e
  - localparam OBI_AW=32, OBI_DW=32
- Sub-module obi_id_fifo:
  - Parameterised depth, 1-bit entries, push/pop/full/empty/count.
  - Synchronous active-high reset.

Test Plan:
1. Fetch only: instr_req=1, addr=32'h80, mem_gnt=1 -> mem_addr=32'h80, be=4'hF, we=0, instr_gnt=1 same cycle; next cycle mem_rvalid=1, rdata=32'h00000013 -> instr_rvalid=1, instr_rdata=32'h13, data_rvalid=0.
2. Tie, round-robin, DATA_PRIO=0: both req every cycle, mem_gnt=1 -> grants alternate I, D, I, D starting with instr after reset; responses are routed in grant order.
3. Stall lock: data req with addr=32'h1000, we=1, wdata=32'hDEADBEEF, mem_gnt=0 for 3 cycles while instr_req rises -> mem_addr stays 32'h1000 all 3 cycles and instr_gnt=0; data_gnt=1 on the 4th cycle.
4. Full: MAX_OUTSTANDING=2, two grants with no rvalid -> mem_req_o=0 while reqs are held. One rvalid -> count=1 and the next request is granted the cycle after.
5. Simultaneous push/pop: grant and rvalid in the same cycle with count=1 -> count stays 1 and the response routes to the older ID.
6. Errors: mem_rvalid_i with count 0 -> err_o=1 next cycle and stays set; rst_i high for 1 cycle -> err_o=0, count=0, last_grant=DATA.
